entity_motion_controller: RTL and testbench
===========================================

Name: entity_motion_controller

Overview:
- Upstream stage of the frame buffer controller: converts synchronised player direction buttons into one 14-bit entity word {ID[3:0], orientation[1:0], tile[7:0]}.
- Position and orientation update only on the frame boundary (rising edge of vsync from the VGA sync generator), so the sprite never tears mid-frame.
- Enforces a per-step frame cooldown and clamps the position at the grid edges.

Parameters:
- GRID_COLS, 16, number of tile columns; column = tile[3:0], legal 0..GRID_COLS-1 (max 16).
- GRID_ROWS, 12, number of tile rows; row = tile[7:4], legal 0..GRID_ROWS-1 (max 16).
- MOVE_PERIOD, 8, frames between consecutive steps while a direction is held (1..255).
- ENTITY_ID, 4'h1, ID placed in entity_out[13:10] when enabled; must not be 4'hF.
- START_TILE, 8'h00, reset tile; must lie inside the grid.

Ports:
- clk  input  1  system pixel clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high = entity active; low = entity channel reported unused.
- vsync  input  1  vsync from the VGA sync generator, same clock domain, any polarity pulse.
- dir_in  input  4  raw buttons {up, down, left, right}, asynchronous (from ui_in).
- entity_out  output  14  {id, orientation, tile} to the frame buffer controller entity channel.
- move_strobe  output  1  one-cycle pulse when the tile changed.

Behaviour:
- One clock, and reset is synchronous and active-high.
- Reset values:
  - tile = START_TILE, orientation = 2'b00, cooldown = 0.
  - entity_out = {ENTITY_ID, 2'b00, START_TILE}; move_strobe = 0.
  - Sync flops = 0; vsync_d = 1, so vsync held high across reset release gives no spurious tick.
- Input sync: dir_in passes through a 2-flop synchroniser to give dir_s. Button-to-decision latency is 2 cycles.
- Frame tick: tick = vsync & ~vsync_d, where vsync_d is registered every cycle. Registered state updates on the clock edge where tick = 1; entity_out reflects the new state 1 cycle later, well inside vblank.
- Direction decode of dir_s:
  - Exactly one bit set = valid direction.
  - Zero bits set = idle.
  - Two or more bits set = invalid; treated like idle for motion, but cooldown is not cleared.
- Orientation encoding: up = 00, right = 01, down = 10, left = 11.
  - On a tick with a valid direction, orientation updates regardless of cooldown or boundary.
- Cooldown counter (8-bit), evaluated on each tick:
  - Idle: cooldown <= 0, so a fresh press steps on the next tick.
  - Valid direction and cooldown = 0: attempt the step, then cooldown <= MOVE_PERIOD-1.
  - Valid or invalid direction and cooldown > 0: cooldown <= cooldown-1, no step.
- Step arithmetic, with clamping and no wrap:
  - up: row-1 if row > 0.
  - down: row+1 if row < GRID_ROWS-1.
  - left: col-1 if col > 0.
  - right: col+1 if col < GRID_COLS-1.
  - A blocked step still reloads cooldown and leaves the tile unchanged.
- move_strobe is high for exactly the one cycle after a tick in which the tile value changed; otherwise 0.
- enable low:
  - entity_out[13:10] = 4'hF (unused channel code); orientation and tile fields hold their last values.
  - tick processing is suppressed: tile, orientation and cooldown are frozen, and move_strobe = 0.
  - On re-enable, processing resumes with the frozen cooldown; ID returns to ENTITY_ID on the next cycle.
- Reset asserted mid-operation overrides everything on the same edge, including a coincident tick.
- vsync edges while dir_s is changing: the decision uses the dir_s value sampled on the tick edge only.
- No combinational path from any input to entity_out; all outputs are registered.

Test Plan:
- Reset, then hold right (dir_in = 4'b0001) for 20 frames with MOVE_PERIOD = 8 → tile steps 00→01 on frame 1, 01→02 on frame 9, 02→03 on frame 17. Orientation = 01; exactly 3 move_strobe pulses, each 1 cycle wide.
- Tap up at tile 8'h00 → tile stays 00, orientation = 00, no move_strobe. Then move to col 15 / row 11 (8'hBF) and press right and down → tile stays BF, orientation updates to 01 then 10.
- Release between taps: left pressed 1 frame, released 1 frame, pressed 1 frame, starting at 8'h05 → tile 04 then 03. Idle clears cooldown, giving 2 strobes in 3 frames.
- Press up and left together (4'b1010) for 5 frames at 8'h55 → tile stays 55, orientation unchanged, no strobe. Cooldown observed decrementing if it was preloaded.
- Deassert enable while right is held → entity_out[13:10] = F, tile and orientation frozen. Reassert → ID = 1 and stepping resumes with the remaining cooldown.
- Assert reset on the same edge as a vsync rise with right held at 8'h33 → next cycle entity_out = {4'h1, 2'b00, 8'h00}, move_strobe = 0. Releasing reset while vsync is high gives no tick until the next rise.

Source files
------------

// File: rtl/entity_motion_controller.sv
// Entity motion controller: turns synchronised direction buttons into a
// 14-bit entity word {id, orientation, tile}. Motion is evaluated only on
// the rising edge of vsync so the sprite never moves mid-frame; a per-step
// frame cooldown paces held buttons and the tile is clamped at the grid edges.
module entity_motion_controller #(
  parameter int          GRID_COLS   = 16,
  parameter int          GRID_ROWS   = 12,
  parameter int          MOVE_PERIOD = 8,
  parameter logic [3:0]  ENTITY_ID   = 4'h1,
  parameter logic [7:0]  START_TILE  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync,
  input  logic [3:0]  dir_in,
  output logic [13:0] entity_out,
  output logic        move_strobe
);

  localparam logic [3:0] COL_MAX   = 4'(GRID_COLS - 1);
  localparam logic [3:0] ROW_MAX   = 4'(GRID_ROWS - 1);
  localparam logic [7:0] CD_RELOAD = 8'(MOVE_PERIOD - 1);
  localparam logic [3:0] UNUSED_ID = 4'hF;

  // dir_in bit positions: {up, down, left, right}
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  logic [3:0] dir_meta;
  logic [3:0] dir_s;
  logic       vsync_d;
  logic       tick;

  logic [7:0] tile;
  logic [1:0] orient;
  logic [7:0] cooldown;
  logic       move_pend;

  logic       dir_idle;
  logic       dir_valid;
  logic [1:0] dir_orient;
  logic [7:0] step_tile;
  logic [3:0] row;
  logic [3:0] col;

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_meta <= '0;
      dir_s    <= '0;
    end else begin
      dir_meta <= dir_in;
      dir_s    <= dir_meta;
    end
  end

  // Delayed vsync for edge detect; resets high so a vsync already high
  // when reset releases does not look like a fresh frame boundary
  always_ff @(posedge clk) begin
    if (reset) vsync_d <= 1'b1;
    else       vsync_d <= vsync;
  end

  assign tick = vsync & ~vsync_d;

  // Decode the synchronised buttons and compute the clamped candidate tile
  always_comb begin
    dir_idle   = (dir_s == 4'b0000);
    dir_valid  = !dir_idle && ((dir_s & (dir_s - 4'd1)) == 4'b0000);
    dir_orient = orient;
    row        = tile[7:4];
    col        = tile[3:0];
    step_tile  = tile;
    case (dir_s)
      DIR_UP: begin
        dir_orient = 2'b00;
        if (row != 4'd0) step_tile = {row - 4'd1, col};
      end
      DIR_RIGHT: begin
        dir_orient = 2'b01;
        if (col < COL_MAX) step_tile = {row, col + 4'd1};
      end
      DIR_DOWN: begin
        dir_orient = 2'b10;
        if (row < ROW_MAX) step_tile = {row + 4'd1, col};
      end
      DIR_LEFT: begin
        dir_orient = 2'b11;
        if (col != 4'd0) step_tile = {row, col - 4'd1};
      end
      default: ;
    endcase
  end

  // Frame-boundary motion state: orientation, tile and step cooldown.
  // Disabled entities freeze everything, including the cooldown.
  always_ff @(posedge clk) begin
    if (reset) begin
      tile      <= START_TILE;
      orient    <= 2'b00;
      cooldown  <= 8'd0;
      move_pend <= 1'b0;
    end else begin
      move_pend <= 1'b0;
      if (tick && enable) begin
        if (dir_idle) begin
          // releasing the buttons lets the next press step immediately
          cooldown <= 8'd0;
        end else if (dir_valid) begin
          orient <= dir_orient;
          if (cooldown == 8'd0) begin
            tile      <= step_tile;
            cooldown  <= CD_RELOAD;
            move_pend <= (step_tile != tile);
          end else begin
            cooldown <= cooldown - 8'd1;
          end
        end else if (cooldown != 8'd0) begin
          // chorded buttons: no motion, but the cooldown keeps running
          cooldown <= cooldown - 8'd1;
        end
      end
    end
  end

  // Output register: entity word and move pulse, one cycle after the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      entity_out  <= {ENTITY_ID, 2'b00, START_TILE};
      move_strobe <= 1'b0;
    end else begin
      entity_out  <= {(enable ? ENTITY_ID : UNUSED_ID), orient, tile};
      move_strobe <= move_pend & enable;
    end
  end

endmodule

// File: tb/tb_entity_motion_controller.sv
// Directed bench for entity_motion_controller: frame pulses on vsync with
// hand-computed tile/orientation/strobe expectations per scenario.
module tb_entity_motion_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        vsync = 1'b0;
  logic [3:0]  dir_in = 4'b0000;
  logic [13:0] entity_out;
  logic        move_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int wide_cnt   = 0;
  logic prev_strobe = 1'b0;

  logic [13:0] exp_word;
  int s0;

  entity_motion_controller dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vsync      (vsync),
    .dir_in     (dir_in),
    .entity_out (entity_out),
    .move_strobe(move_strobe)
  );

  always #5 clk = ~clk;

  // Count strobe pulses and any pulse wider than one cycle
  always @(posedge clk) begin
    if (move_strobe) strobe_cnt <= strobe_cnt + 1;
    if (move_strobe && prev_strobe) wide_cnt <= wide_cnt + 1;
    prev_strobe <= move_strobe;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: vsync high for 2 cycles, low for 3; output settled at return
  task automatic pulse();
    @(negedge clk) vsync = 1'b1;
    wait_neg(2);
    vsync = 1'b0;
    wait_neg(3);
  endtask

  // Press for one frame, release for one frame
  task automatic tap(input logic [3:0] d);
    dir_in = d;
    wait_neg(3);
    pulse();
    dir_in = 4'b0000;
    wait_neg(3);
    pulse();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; vsync = 1'b0; dir_in = 4'b0000; enable = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; dir_in = 4'b0001;
    wait_neg(4);
    exp_word = {4'h1, 2'b00, 8'h00};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL reset_word: got %h expected %h", entity_out, exp_word);
    end
    n_checks++;
    if (move_strobe !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobe: got %b expected 0", move_strobe);
    end
    reset = 1'b0;
    wait_neg(6);
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL reset_vsync_high_no_tick: got %h expected %h", entity_out, exp_word);
    end
    vsync = 1'b0; dir_in = 4'b0000;
    wait_neg(2);
  endtask

  task automatic test_hold_right();
    logic [7:0] et;
    do_reset();
    s0 = strobe_cnt;
    dir_in = 4'b0001;
    wait_neg(3);
    for (int f = 1; f <= 20; f++) begin
      pulse();
      et = (f >= 17) ? 8'h03 : (f >= 9) ? 8'h02 : 8'h01;
      exp_word = {4'h1, 2'b01, et};
      n_checks++;
      if (entity_out !== exp_word) begin
        n_fail++; $display("FAIL hold_right_frame%0d: got %h expected %h", f, entity_out, exp_word);
      end
    end
    n_checks++;
    if (strobe_cnt - s0 !== 3) begin
      n_fail++; $display("FAIL hold_right_strobes: got %0d expected 3", strobe_cnt - s0);
    end
    dir_in = 4'b0000;
    pulse();
  endtask

  task automatic test_boundary();
    do_reset();
    s0 = strobe_cnt;
    tap(4'b1000);
    exp_word = {4'h1, 2'b00, 8'h00};
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt !== s0) begin
      n_fail++; $display("FAIL bound_up_at_00: got %h/%0d expected %h/%0d", entity_out, strobe_cnt, exp_word, s0);
    end
    for (int i = 0; i < 16; i++) tap(4'b0001);
    for (int i = 0; i < 12; i++) tap(4'b0100);
    exp_word = {4'h1, 2'b10, 8'hBF};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL bound_reach_BF: got %h expected %h", entity_out, exp_word);
    end
    n_checks++;
    if (strobe_cnt - s0 !== 26) begin
      n_fail++; $display("FAIL bound_clamp_strobes: got %0d expected 26", strobe_cnt - s0);
    end
    s0 = strobe_cnt;
    tap(4'b0001);
    exp_word = {4'h1, 2'b01, 8'hBF};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL bound_right_at_BF: got %h expected %h", entity_out, exp_word);
    end
    tap(4'b0100);
    exp_word = {4'h1, 2'b10, 8'hBF};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL bound_down_at_BF: got %h expected %h", entity_out, exp_word);
    end
    n_checks++;
    if (strobe_cnt !== s0) begin
      n_fail++; $display("FAIL bound_no_strobe: got %0d expected %0d", strobe_cnt, s0);
    end
  endtask

  task automatic test_release_taps();
    do_reset();
    for (int i = 0; i < 5; i++) tap(4'b0001);
    s0 = strobe_cnt;
    dir_in = 4'b0010; wait_neg(3); pulse();
    exp_word = {4'h1, 2'b11, 8'h04};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL taps_first: got %h expected %h", entity_out, exp_word);
    end
    dir_in = 4'b0000; wait_neg(3); pulse();
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL taps_idle: got %h expected %h", entity_out, exp_word);
    end
    dir_in = 4'b0010; wait_neg(3); pulse();
    exp_word = {4'h1, 2'b11, 8'h03};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL taps_second: got %h expected %h", entity_out, exp_word);
    end
    n_checks++;
    if (strobe_cnt - s0 !== 2) begin
      n_fail++; $display("FAIL taps_strobes: got %0d expected 2", strobe_cnt - s0);
    end
    dir_in = 4'b0000; pulse();
  endtask

  // Ends at 54, left held, cooldown 7; test_enable continues from there
  task automatic test_invalid();
    do_reset();
    for (int i = 0; i < 5; i++) tap(4'b0001);
    for (int i = 0; i < 4; i++) tap(4'b0100);
    dir_in = 4'b0100; wait_neg(3); pulse();
    exp_word = {4'h1, 2'b10, 8'h55};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL invalid_setup: got %h expected %h", entity_out, exp_word);
    end
    s0 = strobe_cnt;
    dir_in = 4'b1010; wait_neg(3);
    for (int i = 0; i < 5; i++) pulse();
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt !== s0) begin
      n_fail++; $display("FAIL invalid_chord: got %h/%0d expected %h/%0d", entity_out, strobe_cnt, exp_word, s0);
    end
    // cooldown should now be 2: two frames of left turn without stepping
    dir_in = 4'b0010; wait_neg(3);
    pulse(); pulse();
    exp_word = {4'h1, 2'b11, 8'h55};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL invalid_cd_remaining: got %h expected %h", entity_out, exp_word);
    end
    pulse();
    exp_word = {4'h1, 2'b11, 8'h54};
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL invalid_then_step: got %h/%0d expected %h/1", entity_out, strobe_cnt - s0, exp_word);
    end
  endtask

  task automatic test_enable();
    pulse();                       // cooldown 7 -> 6
    @(negedge clk) enable = 1'b0;
    wait_neg(1);
    exp_word = {4'hF, 2'b11, 8'h54};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL enable_low_id: got %h expected %h", entity_out, exp_word);
    end
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) pulse();
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt !== s0) begin
      n_fail++; $display("FAIL enable_low_frozen: got %h/%0d expected %h/%0d", entity_out, strobe_cnt, exp_word, s0);
    end
    @(negedge clk) enable = 1'b1;
    wait_neg(1);
    exp_word = {4'h1, 2'b11, 8'h54};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL enable_resume_id: got %h expected %h", entity_out, exp_word);
    end
    for (int i = 0; i < 6; i++) pulse();
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL enable_frozen_cd: got %h expected %h", entity_out, exp_word);
    end
    pulse();
    exp_word = {4'h1, 2'b11, 8'h53};
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL enable_resume_step: got %h/%0d expected %h/1", entity_out, strobe_cnt - s0, exp_word);
    end
  endtask

  task automatic test_reset_tick();
    dir_in = 4'b0000; wait_neg(3); pulse();
    tap(4'b1000); tap(4'b1000);
    exp_word = {4'h1, 2'b00, 8'h33};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL rst_tick_setup: got %h expected %h", entity_out, exp_word);
    end
    dir_in = 4'b0001; wait_neg(3);
    s0 = strobe_cnt;
    @(negedge clk); vsync = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    exp_word = {4'h1, 2'b00, 8'h00};
    n_checks++;
    if (entity_out !== exp_word || move_strobe !== 1'b0) begin
      n_fail++; $display("FAIL rst_tick_same_edge: got %h/%b expected %h/0", entity_out, move_strobe, exp_word);
    end
    @(negedge clk) reset = 1'b0;
    wait_neg(6);
    n_checks++;
    if (entity_out !== exp_word || strobe_cnt !== s0) begin
      n_fail++; $display("FAIL rst_release_vsync_high: got %h/%0d expected %h/%0d", entity_out, strobe_cnt, exp_word, s0);
    end
    vsync = 1'b0; wait_neg(2);
    pulse();
    exp_word = {4'h1, 2'b01, 8'h01};
    n_checks++;
    if (entity_out !== exp_word) begin
      n_fail++; $display("FAIL rst_next_rise_steps: got %h expected %h", entity_out, exp_word);
    end
    dir_in = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_hold_right();
    test_boundary();
    test_release_taps();
    test_invalid();
    test_enable();
    test_reset_tick();
    wait_neg(2);
    n_checks++;
    if (wide_cnt !== 0) begin
      n_fail++; $display("FAIL strobe_width: got %0d wide pulses expected 0", wide_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
